// File: rtl/sap_controlador_sequenciador.sv
// rtl/sap_controlador_sequenciador.sv - SAP-1 control sequencer: one-hot T1..T6 ring counter plus opcode decode
// Drives PC, MAR, RAM, IR, A, B, ALU and output-register control strobes.
module sap_controlador_sequenciador #(
  parameter bit         EARLY_END  = 1'b0,
  parameter logic [3:0] OPCODE_JMP = 4'b0011
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       PC_INC,
  output logic       PC_OUT,
  output logic       jump,
  output logic       MAR_IN,
  output logic       RAM_OUT,
  output logic       IR_IN,
  output logic       IR_OUT,
  output logic       A_IN,
  output logic       A_OUT,
  output logic       B_IN,
  output logic       ALU_OUT,
  output logic       SUB,
  output logic       OUT_IN,
  output logic       halt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state_q, state_d;
  logic     halt_q, halt_d;

  logic is_jmp, is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  logic advance, drive;

  // JMP is decoded first so a relocated OPCODE_JMP overrides any fixed opcode it collides with
  assign is_jmp = (opcode == OPCODE_JMP);
  assign is_lda = !is_jmp && (opcode == 4'b0000);
  assign is_add = !is_jmp && (opcode == 4'b0001);
  assign is_sub = !is_jmp && (opcode == 4'b0010);
  assign is_out = !is_jmp && (opcode == 4'b1110);
  assign is_hlt = !is_jmp && (opcode == 4'b1111);
  assign is_nop = !(is_jmp || is_lda || is_add || is_sub || is_out || is_hlt);

  assign advance = enable && !halt_q;
  assign drive   = clear && enable && !halt_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      T1: if (advance) state_d = T2;
      T2: if (advance) state_d = T3;
      T3: if (advance) state_d = (EARLY_END && is_nop) ? T1 : T4;
      T4: begin
        if (advance) begin
          // HLT parks the ring on T4; only a reset moves it again
          if (is_hlt)
            halt_d = 1'b1;
          else if (EARLY_END && (is_jmp || is_out))
            state_d = T1;
          else
            state_d = T5;
        end
      end
      T5: if (advance) state_d = (EARLY_END && is_lda) ? T1 : T6;
      T6: if (advance) state_d = T1;
      default: state_d = T1;
    endcase
  end

  always_comb begin
    PC_INC  = 1'b0;
    PC_OUT  = 1'b0;
    jump    = 1'b0;
    MAR_IN  = 1'b0;
    RAM_OUT = 1'b0;
    IR_IN   = 1'b0;
    IR_OUT  = 1'b0;
    A_IN    = 1'b0;
    A_OUT   = 1'b0;
    B_IN    = 1'b0;
    ALU_OUT = 1'b0;
    SUB     = 1'b0;
    OUT_IN  = 1'b0;
    if (drive) begin
      case (state_q)
        T1: begin
          PC_OUT = 1'b1;
          MAR_IN = 1'b1;
        end
        T2: PC_INC = 1'b1;
        T3: begin
          RAM_OUT = 1'b1;
          IR_IN   = 1'b1;
        end
        T4: begin
          if (is_jmp) begin
            IR_OUT = 1'b1;
            jump   = 1'b1;
          end else if (is_lda || is_add || is_sub) begin
            IR_OUT = 1'b1;
            MAR_IN = 1'b1;
          end else if (is_out) begin
            A_OUT  = 1'b1;
            OUT_IN = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            RAM_OUT = 1'b1;
            A_IN    = 1'b1;
          end else if (is_add || is_sub) begin
            RAM_OUT = 1'b1;
            B_IN    = 1'b1;
            SUB     = is_sub;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            ALU_OUT = 1'b1;
            A_IN    = 1'b1;
            SUB     = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = state_q;
  assign halt    = halt_q;

endmodule
